mp_alu_seq: RTL and testbench
=============================

# mp_alu_seq

Multi-precision sequencer that drives the 8-bit ALU datapath one byte per cycle to run ADD, SLL and SRL over operands of 1–16 bytes held in the register file. It carries the shift-out/carry bit between bytes through the ALU `ov` chain. It accepts one command via a valid/ready handshake, reads source bytes, issues the ALU op, writes each result byte back, then reports completion with the final carry/shift-out. It sits between the decode/control logic, the register file and the ALU.

## Interface
- `ADDR_W`, 4, register-file address width; addresses wrap mod 2^ADDR_W.
- `LEN_W`, 4, length field width; `len==0` means 2^LEN_W bytes.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_n_i`  in  1  reset, asynchronous and active-low.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  high only in IDLE.
- `cmd_op_i`  in  3  `op_code`; SLL, SRL and ADD are supported.
- `cmd_len_i`  in  LEN_W  byte count (0 = 2^LEN_W).
- `cmd_src_a_i`, `cmd_src_b_i`, `cmd_dst_i`  in  ADDR_W  base addresses; byte i is at base+i, least-significant byte first.
- `cmd_ov_i`  in  1  initial carry/shift-in.
- `rf_raddr_a_o`, `rf_raddr_b_o`  out  ADDR_W  register-file read addresses (combinational read).
- `rf_rdata_a_i`, `rf_rdata_b_i`  in  8  read data.
- `rf_we_o`  out  1  write enable.
- `rf_waddr_o`  out  ADDR_W  write address.
- `rf_wdata_o`  out  8  write data.
- `alu_op_o`  out  9  `{op3, 6'b0}`.
- `alu_rs_o`, `alu_rt_o`  out  8  ALU operands.
- `alu_ov_o`  out  1  ALU shift-in/carry-in.
- `alu_result_i`  in  8  ALU result.
- `alu_ov_i`  in  1  ALU shift-out/carry-out.
- `done_o`  out  1  one-cycle pulse marking completion.
- `err_o`  out  1  qualifies `done_o`; the op was unsupported.
- `ov_final_o`  out  1  final carry; held until the next accept.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN: `cmd_valid_i & cmd_ready_o` with a supported op.
  - IDLE→DONE: accept with an unsupported op; sets `err_o`, performs no writes.
  - RUN→DONE: after the last byte.
  - DONE→IDLE: always.
- At accept, the block latches op, base addresses, byte count `n` and the carry flop (`ov_q <= cmd_ov_i`), and sets index k to 0.
- Byte address order:
  - ADD and SLL: `base+k`, k = 0..n-1.
  - SRL: `base+(n-1-k)`, i.e. most-significant byte first.
  - All address sums are truncated to ADDR_W bits, so addresses wrap.
- In each RUN cycle:
  - `rf_raddr_a_o`/`rf_raddr_b_o` = current source addresses.
  - `alu_rs_o = rf_rdata_a_i`.
  - `alu_rt_o = rf_rdata_b_i` for ADD, 0 otherwise.
  - `alu_ov_o = ov_q`.
  - `rf_we_o = 1`, `rf_waddr_o` = current destination address, `rf_wdata_o = alu_result_i`.
  - At the clock edge, `ov_q <= alu_ov_i`.
- Same-address operation (dst == src) is legal: each byte is read and written in the same cycle.
- Outside RUN, all `rf_*` and `alu_*` outputs are 0.
- While not IDLE, `cmd_valid_i` is ignored and no command is captured.

## Timing
- Reset values:
  - `cmd_ready_o = 1` (state IDLE).
  - All other outputs 0, including `done_o`, `err_o` and `ov_final_o`.
- Reset mid-RUN: the block goes to IDLE immediately and asynchronously. Writes stop and `done_o` is not emitted. Bytes already written stay written.
- Latency, with the accept edge as E0:
  - RUN occupies cycles E0..E0+n-1; writes commit at edges E1..En.
  - DONE occupies cycle En..En+1, with `done_o = 1` and `ov_final_o = ov_q`.
  - `cmd_ready_o` rises at En+1.
  - Throughput is n+1 cycles per command.
- Unsupported op: DONE in the cycle after accept, then back to IDLE.
- `ov_final_o` updates only on entry to DONE.

## Structure
- The shared definitions package already holds the `op_code` enum.
- Add the state enum `seq_state_e` {IDLE, RUN, DONE} to that package.
- No internal sub-module. The ALU stays a sibling instance, wired at the top level, with `alu_op_o` feeding its opcode input.

## Test plan
- ADD, len 2: A at r0/r1 = 0xFF/0x01, B at r4/r5 = 0x01/0x00, dst r8, ov=0 → r8=0x00, r9=0x02, `ov_final_o=0`, `done_o` 2 cycles after accept.
- SLL, len 3, src=dst=r0, bytes 0x80 ×3, ov=1 → each byte 0x01, `ov_final_o=1`.
- SRL, len 2, r1=0x01, r0=0x00, ov=0 → r1 written first to 0x00, then r0=0x80, `ov_final_o=0`.
- Wrap: len=0 (16 bytes), src=dst=14 → exactly 16 writes in address order 14, 15, 0..13; `cmd_ready_o` low for 17 cycles.
- Reset after 2 of 4 RUN writes → all outputs 0 at once, `done_o` never pulses, upper two bytes unchanged, `cmd_ready_o=1`.
- INC command → no `rf_we_o`, `done_o` and `err_o` high 1 cycle after accept; a second `cmd_valid_i` held during DONE is not accepted until IDLE.

Source files
------------

// File: rtl/mp_alu_seq_pkg.sv
// Shared definitions for the multi-precision ALU sequencer: ALU opcodes,
// sequencer state encoding and a helper that classifies the opcodes the
// sequencer can chain byte by byte.
package mp_alu_seq_pkg;

  // 3-bit ALU opcode as carried in the upper bits of the ALU op word
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_INC = 3'd7
  } op_code;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int DATA_W   = 8;
  localparam int ALU_OP_W = 9;

  // Only ops whose carry/shift-out can be chained through ov are sequenced
  function automatic logic is_seq_op(input logic [2:0] op);
    logic ok;
    case (op)
      OP_ADD:  ok = 1'b1;
      OP_SLL:  ok = 1'b1;
      OP_SRL:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: walks an operand of 1..2^LEN_W bytes through
// the 8-bit ALU one byte per cycle, chaining carry/shift-out via ov, and
// writes every result byte back to the register file.
module mp_alu_seq
  import mp_alu_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [2:0]          cmd_op_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [ADDR_W-1:0]   cmd_src_a_i,
  input  logic [ADDR_W-1:0]   cmd_src_b_i,
  input  logic [ADDR_W-1:0]   cmd_dst_i,
  input  logic                cmd_ov_i,
  output logic [ADDR_W-1:0]   rf_raddr_a_o,
  output logic [ADDR_W-1:0]   rf_raddr_b_o,
  input  logic [7:0]          rf_rdata_a_i,
  input  logic [7:0]          rf_rdata_b_i,
  output logic                rf_we_o,
  output logic [ADDR_W-1:0]   rf_waddr_o,
  output logic [7:0]          rf_wdata_o,
  output logic [8:0]          alu_op_o,
  output logic [7:0]          alu_rs_o,
  output logic [7:0]          alu_rt_o,
  output logic                alu_ov_o,
  input  logic [7:0]          alu_result_i,
  input  logic                alu_ov_i,
  output logic                done_o,
  output logic                err_o,
  output logic                ov_final_o
);

  localparam logic [LEN_W:0] ONE_N   = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] LEN_MAX = ONE_N << LEN_W;

  seq_state_e          state_r;
  logic [2:0]          op_r;
  logic [ADDR_W-1:0]   src_a_r;
  logic [ADDR_W-1:0]   src_b_r;
  logic [ADDR_W-1:0]   dst_r;
  logic [LEN_W:0]      n_r;        // byte count, 1..2^LEN_W
  logic [LEN_W-1:0]    k_r;        // bytes already processed
  logic                ov_r;       // carry/shift chain between bytes
  logic                ready_r;
  logic                done_r;
  logic                err_r;
  logic                ov_final_r;

  logic [LEN_W:0]      off_s;
  logic [ADDR_W-1:0]   addr_off_s;
  logic                last_s;

  // Byte offset for the current step: SRL walks from the top byte down
  always_comb begin
    last_s = ({1'b0, k_r} == (n_r - ONE_N));
    if (op_r == OP_SRL) begin
      off_s = n_r - ONE_N - {1'b0, k_r};
    end else begin
      off_s = {1'b0, k_r};
    end
    addr_off_s = ADDR_W'(off_s);
  end

  // Datapath drive: active only in RUN, everything quiet otherwise
  always_comb begin
    rf_raddr_a_o = {ADDR_W{1'b0}};
    rf_raddr_b_o = {ADDR_W{1'b0}};
    rf_we_o      = 1'b0;
    rf_waddr_o   = {ADDR_W{1'b0}};
    rf_wdata_o   = 8'h00;
    alu_op_o     = 9'h000;
    alu_rs_o     = 8'h00;
    alu_rt_o     = 8'h00;
    alu_ov_o     = 1'b0;
    if (state_r == RUN) begin
      rf_raddr_a_o = src_a_r + addr_off_s;
      rf_raddr_b_o = src_b_r + addr_off_s;
      rf_we_o      = 1'b1;
      rf_waddr_o   = dst_r + addr_off_s;
      rf_wdata_o   = alu_result_i;
      alu_op_o     = {op_r, 6'b000000};
      alu_rs_o     = rf_rdata_a_i;
      alu_rt_o     = (op_r == OP_ADD) ? rf_rdata_b_i : 8'h00;
      alu_ov_o     = ov_r;
    end else begin
      alu_ov_o     = 1'b0;
    end
  end

  // Control FSM with registered handshake and completion outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      op_r       <= 3'd0;
      src_a_r    <= {ADDR_W{1'b0}};
      src_b_r    <= {ADDR_W{1'b0}};
      dst_r      <= {ADDR_W{1'b0}};
      n_r        <= {(LEN_W+1){1'b0}};
      k_r        <= {LEN_W{1'b0}};
      ov_r       <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      ov_final_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          if (cmd_valid_i && ready_r) begin
            op_r    <= cmd_op_i;
            src_a_r <= cmd_src_a_i;
            src_b_r <= cmd_src_b_i;
            dst_r   <= cmd_dst_i;
            n_r     <= (cmd_len_i == {LEN_W{1'b0}}) ? LEN_MAX : {1'b0, cmd_len_i};
            k_r     <= {LEN_W{1'b0}};
            ov_r    <= cmd_ov_i;
            ready_r <= 1'b0;
            if (is_seq_op(cmd_op_i)) begin
              state_r <= RUN;
            end else begin
              // Unsupported op: report immediately, touch nothing
              state_r    <= DONE;
              done_r     <= 1'b1;
              err_r      <= 1'b1;
              ov_final_r <= cmd_ov_i;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          ov_r <= alu_ov_i;
          k_r  <= k_r + LEN_W'(1);
          if (last_s) begin
            state_r    <= DONE;
            done_r     <= 1'b1;
            err_r      <= 1'b0;
            ov_final_r <= alu_ov_i;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign ov_final_o  = ov_final_r;

endmodule

// File: tb/tb_mp_alu_seq.sv
// Self-checking bench for mp_alu_seq: models the register file and ALU,
// predicts every write into a scoreboard queue and checks completion timing.
module tb_mp_alu_seq;
  import mp_alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_len, cmd_src_a, cmd_src_b, cmd_dst;
  logic       cmd_ov;
  logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic       rf_we;
  logic [8:0] alu_op;
  logic [7:0] alu_rs, alu_rt, alu_result;
  logic       alu_ov, alu_ov_out;
  logic       done, err, ov_final;

  logic [7:0] mem [16];
  logic       pl_we;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [3:0]   len, sa, sb, dst;
    logic         ov;
    logic [127:0] init;
    logic         exp_ovf, exp_err;
    logic [3:0]   ca0; logic [7:0] cv0;
    logic [3:0]   ca1; logic [7:0] cv1;
  } vec_t;
  vec_t vecs [8];

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  logic [2:0] cur_op = 3'd0;

  mp_alu_seq #(.ADDR_W(4), .LEN_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_len_i(cmd_len), .cmd_src_a_i(cmd_src_a), .cmd_src_b_i(cmd_src_b),
    .cmd_dst_i(cmd_dst), .cmd_ov_i(cmd_ov),
    .rf_raddr_a_o(rf_raddr_a), .rf_raddr_b_o(rf_raddr_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .alu_op_o(alu_op), .alu_rs_o(alu_rs), .alu_rt_o(alu_rt), .alu_ov_o(alu_ov),
    .alu_result_i(alu_result), .alu_ov_i(alu_ov_out),
    .done_o(done), .err_o(err), .ov_final_o(ov_final)
  );

  always #5 clk = ~clk;

  // Reference ALU byte step: returns {carry/shift-out, result}
  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] rs,
                                         input logic [7:0] rt, input logic cin);
    case (op)
      OP_ADD:  return {1'b0, rs} + {1'b0, rt} + {8'h00, cin};
      OP_SLL:  return {rs[7], rs[6:0], cin};
      OP_SRL:  return {rs[0], cin, rs[7:1]};
      default: return {1'b0, rs};
    endcase
  endfunction

  // ALU sibling model
  always_comb {alu_ov_out, alu_result} = ref_alu(alu_op[8:6], alu_rs, alu_rt, alu_ov);

  assign rf_rdata_a = mem[rf_raddr_a];
  assign rf_rdata_b = mem[rf_raddr_b];

  // Register file write port (DUT) plus bench preload port
  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic preload(input logic [127:0] init);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_addr = 4'(i); pl_data = init[8*i +: 8];
    end
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Predict the write sequence from the current register-file contents
  task automatic push_expected(input logic [2:0] op, input logic [3:0] len, input logic [3:0] sa,
                               input logic [3:0] sb, input logic [3:0] dst, input logic ov);
    logic [7:0] rm [16];
    logic [8:0] r;
    logic [3:0] off;
    logic c;
    int n;
    wr_t w;
    for (int i = 0; i < 16; i++) rm[i] = mem[i];
    n = (len == 4'd0) ? 16 : int'(len);
    c = ov;
    if (op == OP_ADD || op == OP_SLL || op == OP_SRL) begin
      for (int k = 0; k < n; k++) begin
        off = (op == OP_SRL) ? 4'(n - 1 - k) : 4'(k);
        r = ref_alu(op, rm[sa + off], (op == OP_ADD) ? rm[sb + off] : 8'h00, c);
        c = r[8];
        w.addr = dst + off; w.data = r[7:0];
        rm[w.addr] = w.data;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic do_cmd(input int idx, input logic [2:0] op, input logic [3:0] len, input logic [3:0] sa,
                        input logic [3:0] sb, input logic [3:0] dst, input logic ov,
                        input logic exp_ovf, input logic exp_err);
    int n, exp_lat, cyc, rdy_low;
    n = (len == 4'd0) ? 16 : int'(len);
    exp_lat = (op == OP_ADD || op == OP_SLL || op == OP_SRL) ? n + 1 : 1;
    push_expected(op, len, sa, sb, dst, ov);
    @(negedge clk);
    check($sformatf("v%0d ready_before", idx), 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst; cmd_ov = ov; cur_op = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0; rdy_low = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!cmd_ready) rdy_low++;
      if (done) break;
    end
    check($sformatf("v%0d latency", idx), 64'(cyc), 64'(exp_lat));
    check($sformatf("v%0d err", idx), 64'(err), 64'(exp_err));
    check($sformatf("v%0d ov_final", idx), 64'(ov_final), 64'(exp_ovf));
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
    check($sformatf("v%0d ready_after", idx), 64'(cmd_ready), 64'd1);
    check($sformatf("v%0d ready_low_cycles", idx), 64'(rdy_low), 64'(exp_lat));
    check($sformatf("v%0d ov_final_held", idx), 64'(ov_final), 64'(exp_ovf));
    check($sformatf("v%0d writes_left", idx), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    wr_t e;
    int wr0, dn0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_len = 4'd0;
    cmd_src_a = 4'd0; cmd_src_b = 4'd0; cmd_dst = 4'd0; cmd_ov = 1'b0;
    pl_we = 1'b0; pl_addr = 4'd0; pl_data = 8'h00;

    // Scoreboard monitor: compare each write, require quiet outputs otherwise
    fork
      forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (rf_we) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, no write expected", rf_waddr, rf_wdata);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(rf_waddr), 64'(e.addr));
            check("wr_data", 64'(rf_wdata), 64'(e.data));
            check("alu_op", 64'(alu_op), 64'({cur_op, 6'b000000}));
          end
        end else begin
          check("quiet_outputs", 64'({rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_op, alu_rs, alu_rt, alu_ov}), 64'd0);
        end
      end
    join_none

    vecs[0] = '{OP_ADD, 4'd2, 4'd0, 4'd4, 4'd8, 1'b0, 128'h0000_0000_0000_0000_0000_0001_0000_01FF,
                1'b0, 1'b0, 4'd8, 8'h00, 4'd9, 8'h02};
    vecs[1] = '{OP_SLL, 4'd3, 4'd0, 4'd0, 4'd0, 1'b1, 128'h0000_0000_0000_0000_0000_0000_0080_8080,
                1'b1, 1'b0, 4'd0, 8'h01, 4'd2, 8'h01};
    vecs[2] = '{OP_SRL, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 128'h0000_0000_0000_0000_0000_0000_0000_0100,
                1'b0, 1'b0, 4'd1, 8'h00, 4'd0, 8'h80};
    vecs[3] = '{OP_SLL, 4'd0, 4'd14, 4'd0, 4'd14, 1'b0, {16{8'h81}},
                1'b1, 1'b0, 4'd14, 8'h02, 4'd0, 8'h03};
    vecs[4] = '{OP_ADD, 4'd4, 4'd0, 4'd4, 4'd0, 1'b0, 128'h0000_0000_0000_0000_0000_0001_FFFF_FFFF,
                1'b1, 1'b0, 4'd0, 8'h00, 4'd3, 8'h00};
    vecs[5] = '{OP_INC, 4'd3, 4'd0, 4'd0, 4'd0, 1'b1, 128'h0000_0000_0000_0000_0000_0000_0000_BBAA,
                1'b1, 1'b1, 4'd0, 8'hAA, 4'd1, 8'hBB};
    vecs[6] = '{OP_SRL, 4'd3, 4'd5, 4'd0, 4'd10, 1'b1, 128'h0000_0000_0000_0000_0104_0200_0000_0000,
                1'b0, 1'b0, 4'd12, 8'h80, 4'd11, 8'h82};
    vecs[7] = '{OP_ADD, 4'd1, 4'd15, 4'd15, 4'd15, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                1'b1, 1'b0, 4'd15, 8'h01, 4'd14, 8'h00};

    #12;
    check("reset_ready", 64'(cmd_ready), 64'd1);
    check("reset_flags", 64'({done, err, ov_final, rf_we}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      preload(vecs[v].init);
      wr0 = wr_cnt;
      do_cmd(v, vecs[v].op, vecs[v].len, vecs[v].sa, vecs[v].sb, vecs[v].dst, vecs[v].ov,
             vecs[v].exp_ovf, vecs[v].exp_err);
      check($sformatf("v%0d write_count", v), 64'(wr_cnt - wr0),
            64'((vecs[v].op == OP_INC) ? 0 : ((vecs[v].len == 4'd0) ? 16 : int'(vecs[v].len))));
      check($sformatf("v%0d byte_a", v), 64'(mem[vecs[v].ca0]), 64'(vecs[v].cv0));
      check($sformatf("v%0d byte_b", v), 64'(mem[vecs[v].ca1]), 64'(vecs[v].cv1));
    end

    // Reset after two of four writes of an SLL into r8..r11
    preload(128'h0000_0000_0000_0000_0000_0000_4433_2211);
    push_expected(OP_SLL, 4'd4, 4'd0, 4'd0, 4'd8, 1'b0);
    dn0 = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SLL; cmd_len = 4'd4; cmd_src_a = 4'd0;
    cmd_src_b = 4'd0; cmd_dst = 4'd8; cmd_ov = 1'b0; cur_op = OP_SLL;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_outputs", 64'({done, err, ov_final, rf_we, rf_waddr, rf_wdata, alu_op, rf_raddr_a}), 64'd0);
    check("rst_mid_pending", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt - dn0), 64'd0);
    check("rst_mid_bytes", 64'({mem[8], mem[9], mem[10], mem[11]}), 64'h2244_0000);
    check("rst_mid_ready_after", 64'(cmd_ready), 64'd1);

    // INC then a command held valid through DONE: accepted only back in IDLE
    preload(128'h9000_0000_0000_0000_0000_0000_0000_0000);
    dn0 = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_INC; cmd_len = 4'd2; cmd_src_a = 4'd0;
    cmd_src_b = 4'd0; cmd_dst = 4'd0; cmd_ov = 1'b0; cur_op = OP_INC;
    @(posedge clk);
    #1;
    push_expected(OP_ADD, 4'd1, 4'd15, 4'd15, 4'd15, 1'b0);
    cmd_op = OP_ADD; cmd_len = 4'd1; cmd_src_a = 4'd15; cmd_src_b = 4'd15; cmd_dst = 4'd15;
    cur_op = OP_ADD;
    @(negedge clk);
    check("inc_done_err", 64'({done, err, cmd_ready, rf_we}), 64'b1100);
    @(negedge clk);
    check("inc_back_idle", 64'({done, err, cmd_ready}), 64'b001);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("held_cmd_run", 64'({done, cmd_ready}), 64'b00);
    @(negedge clk);
    check("held_cmd_done", 64'({done, err, ov_final}), 64'b101);
    @(negedge clk);
    check("held_cmd_result", 64'(mem[15]), 64'h20);
    check("inc_seq_done_pulses", 64'(done_cnt - dn0), 64'd2);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
